// File: rtl/pico_sw_handshake.sv
// Switch/LED front end for the picoMIPS wrapper: clock enable, step debounce, operand handshake, LED register.
// Latency: step_level/in_valid follow sw_step after 2+DB_CYCLES fastclk edges; led updates the edge after a cpu_en write.
// Backpressure: one operand slot; a step while the slot is still full is dropped and flagged sticky in overrun.
module pico_sw_handshake #(
    parameter int DATA_W    = 8,
    parameter int OUT_W     = 8,
    parameter int N         = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic              fastclk,
    input  logic              nreset,
    input  logic              sw_step,
    input  logic [DATA_W-1:0] sw_data,
    output logic              cpu_en,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [OUT_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              step_level,
    output logic [OUT_W-1:0]  led,
    output logic              overrun,
    output logic [7:0]        xfer_cnt
);

    localparam int DBW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        FULL    = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           sync1, sync2;
    logic [DBW-1:0] db_cnt;
    logic           db_flip, rise, fall, level_nxt, rd;
    logic           capture, drop;

    generate
        if (N == 0) begin : g_en_const
            assign cpu_en = 1'b1;
        end else begin : g_div
            localparam logic [N-1:0] DIV_ONE = 1;
            logic [N-1:0] div_cnt;
            always_ff @(posedge fastclk or negedge nreset) begin
                if (!nreset) div_cnt <= '0;
                else         div_cnt <= div_cnt + DIV_ONE;
            end
            assign cpu_en = &div_cnt;
        end
    endgenerate

    assign db_flip   = (sync2 != step_level) && (db_cnt == DBW'(DB_CYCLES - 1));
    assign rise      = db_flip & ~step_level;
    assign fall      = db_flip & step_level;
    assign level_nxt = step_level ^ db_flip;
    assign rd        = cpu_en & cpu_rd;

    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_cnt     <= '0;
            step_level <= 1'b0;
        end else begin
            sync1 <= sw_step;
            sync2 <= sync1;
            if (sync2 == step_level || db_flip) db_cnt <= '0;
            else                                db_cnt <= db_cnt + DBW'(1);
            if (db_flip) step_level <= ~step_level;
        end
    end

    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) state <= WAIT_HI;
        else         state <= state_nxt;
    end

    // A read that coincides with a fall must not park in WAIT_LO, so use the post-edge level.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            WAIT_HI: begin
                if (rise) begin
                    capture   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (rise) begin
                    if (rd) capture = 1'b1;
                    else    drop    = 1'b1;
                end else if (rd) begin
                    state_nxt = level_nxt ? WAIT_LO : WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (fall) state_nxt = WAIT_HI;
            end
            default: state_nxt = WAIT_HI;
        endcase
    end

    assign in_valid = (state == FULL);

    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            in_data  <= '0;
            xfer_cnt <= '0;
            overrun  <= 1'b0;
            led      <= '0;
        end else begin
            if (capture) begin
                in_data  <= sw_data;
                xfer_cnt <= xfer_cnt + 8'd1;
            end
            if (drop) overrun <= 1'b1;
            if (cpu_en && cpu_wr) led <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_pico_sw_handshake.sv
// Directed bench for pico_sw_handshake: window-based debounce model plus operand-slot model, checked every cycle.
module tb_pico_sw_handshake;

    localparam int DW = 8;
    localparam int OW = 8;
    localparam int NB = 2;
    localparam int DB = 4;
    localparam int P  = 1 << NB;

    logic          fastclk = 1'b0;
    logic          nreset  = 1'b0;
    logic          sw_step = 1'b0;
    logic [DW-1:0] sw_data = '0;
    logic          cpu_rd  = 1'b0;
    logic          cpu_wr  = 1'b0;
    logic [OW-1:0] cpu_wdata = '0;

    logic          cpu_en, in_valid, step_level, overrun;
    logic [DW-1:0] in_data;
    logic [OW-1:0] led;
    logic [7:0]    xfer_cnt;

    logic          cpu_en0, in_valid0, step_level0, overrun0;
    logic [DW-1:0] in_data0;
    logic [OW-1:0] led0;
    logic [7:0]    xfer_cnt0;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_on = 1'b1;

    pico_sw_handshake #(.DATA_W(DW), .OUT_W(OW), .N(NB), .DB_CYCLES(DB)) dut (
        .fastclk(fastclk), .nreset(nreset), .sw_step(sw_step), .sw_data(sw_data),
        .cpu_en(cpu_en), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .in_data(in_data), .in_valid(in_valid), .step_level(step_level), .led(led),
        .overrun(overrun), .xfer_cnt(xfer_cnt)
    );

    // Undivided build with the CPU side idle: only the first step is ever taken.
    pico_sw_handshake #(.DATA_W(DW), .OUT_W(OW), .N(0), .DB_CYCLES(DB)) dut0 (
        .fastclk(fastclk), .nreset(nreset), .sw_step(sw_step), .sw_data(sw_data),
        .cpu_en(cpu_en0), .cpu_rd(1'b0), .cpu_wr(1'b0), .cpu_wdata(cpu_wdata),
        .in_data(in_data0), .in_valid(in_valid0), .step_level(step_level0), .led(led0),
        .overrun(overrun0), .xfer_cnt(xfer_cnt0)
    );

    always #10 fastclk = ~fastclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit en_at(input int e);
        return (e % P) == (P - 1);
    endfunction

    // Model: level flips when the last DB synchronised samples all disagree with it.
    bit        hq[$];
    bit        m_lvl, m_valid, m_ovr, m0_valid, m0_ovr;
    bit        tog, rise, rd;
    logic [7:0] m_data, m_led, m_xfer, m0_data, m0_xfer;
    int        m_e;

    always @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            hq.delete();
            for (int i = 0; i <= DB; i++) hq.push_back(1'b0);
            m_lvl = 0; m_valid = 0; m_ovr = 0; m_data = 0; m_led = 0; m_xfer = 0; m_e = 0;
            m0_valid = 0; m0_ovr = 0; m0_data = 0; m0_xfer = 0;
        end else begin
            rd  = en_at(m_e) && cpu_rd;
            tog = 1;
            for (int i = 0; i < DB; i++) if (hq[i] == m_lvl) tog = 0;
            rise = tog && !m_lvl;
            if (rise && (!m_valid || rd)) begin
                m_data = sw_data; m_xfer = m_xfer + 8'd1; m_valid = 1;
            end else if (rise) begin
                m_ovr = 1;
            end else if (m_valid && rd) begin
                m_valid = 0;
            end
            if (rise && !m0_valid) begin
                m0_data = sw_data; m0_xfer = m0_xfer + 8'd1; m0_valid = 1;
            end else if (rise) begin
                m0_ovr = 1;
            end
            if (en_at(m_e) && cpu_wr) m_led = cpu_wdata;
            if (tog) m_lvl = !m_lvl;
            hq.push_back(sw_step);
            void'(hq.pop_front());
            m_e++;
        end
    end

    always @(posedge fastclk) begin
        #2;
        if (cmp_on) begin
            chk("cpu_en", cpu_en, en_at(m_e));
            chk("step_level", step_level, m_lvl);
            chk("in_valid", in_valid, m_valid);
            chk("in_data", in_data, m_data);
            chk("xfer_cnt", xfer_cnt, m_xfer);
            chk("overrun", overrun, m_ovr);
            chk("led", led, m_led);
            chk("n0_cpu_en", cpu_en0, 1);
            chk("n0_step_level", step_level0, m_lvl);
            chk("n0_in_valid", in_valid0, m0_valid);
            chk("n0_in_data", in_data0, m0_data);
            chk("n0_xfer_cnt", xfer_cnt0, m0_xfer);
            chk("n0_overrun", overrun0, m0_ovr);
            chk("n0_led", led0, 0);
        end
    end

    task automatic sync_en();
        int k;
        k = 0;
        @(negedge fastclk);
        while (!cpu_en && k < 16) begin
            @(negedge fastclk);
            k++;
        end
        chk("en_found", cpu_en, 1);
    endtask

    task automatic step_cycle(input logic [7:0] d);
        @(negedge fastclk);
        sw_data = d;
        sw_step = 1'b1;
        repeat (8) @(negedge fastclk);
        sw_step = 1'b0;
        repeat (8) @(negedge fastclk);
    endtask

    initial begin
        int k;
        #99;
        chk("rst_in_valid", in_valid, 0);
        chk("rst_led", led, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_cpu_en", cpu_en, 0);
        @(negedge fastclk);
        nreset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge fastclk); #2;
            chk($sformatf("div_c%0d", c), cpu_en, (c % 4) == 3);
        end

        // Basic step: level and in_valid exactly 6 edges after the switch.
        @(negedge fastclk);
        sw_data = 8'h04; sw_step = 1'b1;
        repeat (5) @(posedge fastclk);
        #2 chk("basic_early_lvl", step_level, 0);
        @(posedge fastclk); #2;
        chk("basic_lvl", step_level, 1);
        chk("basic_valid", in_valid, 1);
        chk("basic_data", in_data, 8'h04);
        chk("basic_xfer", xfer_cnt, 1);
        @(negedge fastclk);
        cpu_rd = 1'b1;
        k = 0;
        while (in_valid && k < 8) begin
            @(posedge fastclk); #2;
            k++;
        end
        chk("basic_rd_drop", in_valid, 0);
        repeat (6) @(negedge fastclk);
        chk("basic_wait_lo", in_valid, 0);
        sw_step = 1'b0;
        repeat (8) @(negedge fastclk);

        // Second operand with cpu_rd held throughout.
        sw_data = 8'h08; sw_step = 1'b1;
        repeat (6) @(posedge fastclk);
        #2 chk("second_data", in_data, 8'h08);
        chk("second_xfer", xfer_cnt, 2);
        repeat (12) @(negedge fastclk);
        chk("second_once_xfer", xfer_cnt, 2);
        chk("second_once_valid", in_valid, 0);
        sw_step = 1'b0; cpu_rd = 1'b0;
        repeat (8) @(negedge fastclk);

        // 3-cycle glitch is filtered.
        sw_step = 1'b1;
        repeat (3) @(negedge fastclk);
        sw_step = 1'b0;
        repeat (10) @(negedge fastclk);
        chk("glitch_lvl", step_level, 0);
        chk("glitch_valid", in_valid, 0);
        chk("glitch_xfer", xfer_cnt, 2);

        // Fill the slot, then land a read exactly on the next rise edge.
        step_cycle(8'h2A);
        chk("fill_valid", in_valid, 1);
        sync_en();
        repeat (3) @(negedge fastclk);
        sw_data = 8'h33; sw_step = 1'b1;
        repeat (5) @(negedge fastclk);
        cpu_rd = 1'b1;
        @(posedge fastclk); #2;
        chk("simul_lvl", step_level, 1);
        chk("simul_data", in_data, 8'h33);
        chk("simul_xfer", xfer_cnt, 4);
        chk("simul_ovr", overrun, 0);
        chk("simul_valid", in_valid, 1);
        repeat (6) @(negedge fastclk);
        chk("simul_consumed", in_valid, 0);
        sw_step = 1'b0;
        repeat (8) @(negedge fastclk);
        cpu_rd = 1'b0;

        // Two steps with no read: second one dropped.
        step_cycle(8'h11);
        step_cycle(8'h22);
        chk("ovr_flag", overrun, 1);
        chk("ovr_data", in_data, 8'h11);
        chk("ovr_xfer", xfer_cnt, 5);
        chk("ovr_valid", in_valid, 1);

        // LED write only lands on a cpu_en edge.
        sync_en();
        @(negedge fastclk);
        cpu_wr = 1'b1; cpu_wdata = 8'h20;
        @(posedge fastclk); #2 chk("led_no_en", led, 0);
        repeat (2) @(posedge fastclk);
        #2 chk("led_still", led, 0);
        @(posedge fastclk); #2 chk("led_set", led, 8'h20);
        @(negedge fastclk);
        cpu_wr = 1'b0;

        // Asynchronous reset with an operand pending, step held across release.
        chk("pre_rst_valid", in_valid, 1);
        #3 nreset = 1'b0;
        #1;
        chk("arst_led", led, 0);
        chk("arst_valid", in_valid, 0);
        chk("arst_xfer", xfer_cnt, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_lvl", step_level, 0);
        sw_data = 8'h5A; sw_step = 1'b1;
        repeat (3) @(negedge fastclk);
        nreset = 1'b1;
        repeat (5) @(posedge fastclk);
        #2 chk("rel_early_lvl", step_level, 0);
        @(posedge fastclk); #2;
        chk("rel_lvl", step_level, 1);
        chk("rel_valid", in_valid, 1);
        chk("rel_data", in_data, 8'h5A);
        chk("rel_xfer", xfer_cnt, 1);
        repeat (2) @(negedge fastclk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pico_sw_handshake.md
Name: pico_sw_handshake

Overview:
- Parametrised switch/LED front end for the picoMIPS test wrapper.
- Generates the divided CPU clock enable and synchronises and debounces the step switch (board SW[8]).
- Runs a step/data handshake so each operand on the data switches (SW[7:0]) is delivered to the CPU exactly once.
- Registers the CPU result onto the LEDs; flags operator overruns and counts transfers.

Parameters:
- DATA_W, 8, width of switch data / in_data
- OUT_W, 8, width of LED output
- N, 2, clock-enable divider exponent; cpu_en pulses once every 2^N fastclk cycles (N=0: cpu_en constantly 1)
- DB_CYCLES, 4, consecutive stable synchronised samples required to change debounced step level (>=1)

Ports:
- fastclk  in  1  board clock; all state on its rising edge
- nreset  in  1  asynchronous, active-low reset
- sw_step  in  1  raw step switch, asynchronous to fastclk
- sw_data  in  DATA_W  raw data switches, static while sw_step is high
- cpu_en  out  1  CPU clock enable
- cpu_rd  in  1  CPU consumes in_data; honoured only when cpu_en=1
- cpu_wr  in  1  CPU LED write; honoured only when cpu_en=1
- cpu_wdata  in  OUT_W  LED write data
- in_data  out  DATA_W  captured operand
- in_valid  out  1  in_data holds an unconsumed operand
- step_level  out  1  debounced step switch level
- led  out  OUT_W  LED register
- overrun  out  1  sticky: a step was dropped
- xfer_cnt  out  8  number of captures, modulo 256

Behaviour:
- Reset (async assert, sync-release domain fastclk):
  - all outputs 0; divider counter 0; synchroniser flops 0; debounce counter 0; FSM WAIT_HI.
- Divider:
  - N-bit up-counter, wraps; cpu_en = (counter == all-ones).
  - First cpu_en is high during cycle 2^N-1 after reset release, then every 2^N cycles.
- Synchroniser / debounce:
  - 2-flop synchroniser on sw_step.
  - Counter counts consecutive cycles where the synchronised value != step_level; clears on any match.
  - On reaching DB_CYCLES, step_level toggles and the counter clears.
  - Latency from sw_step change to step_level change: 2+DB_CYCLES fastclk edges.
  - A glitch shorter than DB_CYCLES synchronised cycles is ignored.
- Rise event: the edge on which step_level goes 0->1. Fall event: step_level goes 1->0.
- FSM (in_valid = state==FULL):
  - WAIT_HI: rise -> capture sw_data into in_data, xfer_cnt+1, go FULL. in_valid rises on the same edge as step_level.
  - FULL, read (cpu_en&cpu_rd) with no rise: go WAIT_LO if step_level=1, else WAIT_HI.
  - FULL, rise with no read: set overrun; in_data unchanged; new operand dropped; xfer_cnt unchanged; stay FULL.
  - FULL, read and rise on the same edge: capture new data, xfer_cnt+1, stay FULL, no overrun.
  - WAIT_LO: fall -> WAIT_HI. cpu_rd is ignored, so there is no double delivery.
  - Reads while not FULL have no effect.
- LED: on cpu_en&cpu_wr, led <= cpu_wdata, visible the next cycle; otherwise hold.
- Counters: xfer_cnt wraps 255->0. overrun is cleared only by nreset.
- Reset mid-operation: everything returns to reset values immediately, including a pending in_valid and a partially debounced step. After release, a step already held high is seen as a fresh rise after 2+DB_CYCLES edges.

Test Plan:
- Reset and divider: N=2, fastclk period 20 ns, nreset low 100 ns then high -> all outputs 0; cpu_en pulses at cycles 3, 7, 11 after release; N=0 build -> cpu_en constantly 1.
- Basic step: sw_data=8'h04, raise sw_step -> step_level and in_valid high exactly 6 edges later with in_data=8'h04, xfer_cnt=1. cpu_rd held -> in_valid drops on the next cpu_en edge; state WAIT_LO while the step is held.
- Second operand: drop sw_step, set 8'h08, raise -> in_data=8'h08, xfer_cnt=2; holding cpu_rd across the whole high phase delivers it exactly once.
- Debounce: 3-cycle high pulse on sw_step (DB_CYCLES=4) -> no step_level change, in_valid stays 0.
- Overrun and simultaneous events:
  - Step cycled twice with no cpu_rd -> overrun=1, in_data holds the first value, xfer_cnt +1 only.
  - Read and rise on the same edge -> new data captured, overrun stays 0.
- LED and reset: cpu_wr=1, cpu_wdata=8'h20 -> led=8'h20 only after a cpu_en edge. Assert nreset while in_valid=1 -> led, in_valid, xfer_cnt and overrun all 0 asynchronously.
